// File: rtl/ahblite_gpio_irq.sv
// AHB-Lite GPIO slave with per-pin direction, edge-capture interrupts (W1C) and one level irq.
// Optional input debounce filter is enabled by defining GPIO_DEBOUNCE_EN.
module ahblite_gpio_irq #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             HSEL,
    input  logic [31:0]      HADDR,
    input  logic [1:0]       HTRANS,
    input  logic [2:0]       HSIZE,
    input  logic [3:0]       HPROT,
    input  logic             HWRITE,
    input  logic [31:0]      HWDATA,
    input  logic             HREADY,
    output logic             HREADYOUT,
    output logic [31:0]      HRDATA,
    output logic             HRESP,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    localparam logic [2:0] OFS_DATA_OUT = 3'd0;
    localparam logic [2:0] OFS_DATA_IN  = 3'd1;
    localparam logic [2:0] OFS_DIR      = 3'd2;
    localparam logic [2:0] OFS_IRQ_EN   = 3'd3;
    localparam logic [2:0] OFS_RISE     = 3'd4;
    localparam logic [2:0] OFS_FALL     = 3'd5;
    localparam logic [2:0] OFS_STATUS   = 3'd6;
    localparam logic [2:0] OFS_ID       = 3'd7;
    localparam logic [7:0] ID_WIDTH     = 8'(WIDTH);

    logic             vld_p1;
    logic             write_p1;
    logic [2:0]       addr_p1;

    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] irq_en;
    logic [WIDTH-1:0] rise_mask;
    logic [WIDTH-1:0] fall_mask;
    logic [WIDTH-1:0] irq_status;

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] prev;

    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] set_term;
    logic [31:0]      rd_data;

    logic             unused_bus;
    assign unused_bus = ^{HSIZE, HPROT, HADDR[31:5], HADDR[1:0], HWDATA};

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;

    // Address phase -> data phase
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            vld_p1   <= 1'b0;
            write_p1 <= 1'b0;
            addr_p1  <= 3'd0;
        end else if (HREADY) begin
            vld_p1   <= HSEL & HTRANS[1];
            write_p1 <= HWRITE;
            addr_p1  <= HADDR[4:2];
        end
    end

    assign wr_en = vld_p1 & write_p1;
    assign wdata = HWDATA[WIDTH-1:0];

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            data_out  <= '0;
            dir       <= '0;
            irq_en    <= '0;
            rise_mask <= '0;
            fall_mask <= '0;
        end else if (wr_en) begin
            case (addr_p1)
                OFS_DATA_OUT: data_out  <= wdata;
                OFS_DIR:      dir       <= wdata;
                OFS_IRQ_EN:   irq_en    <= wdata;
                OFS_RISE:     rise_mask <= wdata;
                OFS_FALL:     fall_mask <= wdata;
                default:      ;
            endcase
        end
    end

    // Input synchroniser and edge history
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            meta <= '0;
            sync <= '0;
            prev <= '0;
        end else begin
            meta <= gpio_in;
            sync <= meta;
            prev <= filt;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt [WIDTH];

    // A pin's counter only runs while sync disagrees with filt; any return to agreement restarts it.
    for (genvar i = 0; i < WIDTH; i++) begin : g_deb
        always_ff @(posedge HCLK or posedge HRESET) begin
            if (HRESET) begin
                cnt[i]  <= '0;
                filt[i] <= 1'b0;
            end else if (sync[i] == filt[i]) begin
                cnt[i]  <= '0;
            end else if (cnt[i] == CNT_LAST) begin
                cnt[i]  <= '0;
                filt[i] <= sync[i];
            end else begin
                cnt[i]  <= cnt[i] + 1'b1;
            end
        end
    end
`else
    assign filt = sync;
`endif

    assign set_term = (filt & ~prev & rise_mask) | (~filt & prev & fall_mask);
    assign w1c      = (wr_en && addr_p1 == OFS_STATUS) ? wdata : '0;

    // Set is applied after clear so a simultaneous edge keeps the bit
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            irq_status <= '0;
        end else begin
            irq_status <= (irq_status & ~w1c) | set_term;
        end
    end

    always_comb begin
        rd_data = 32'd0;
        case (addr_p1)
            OFS_DATA_OUT: rd_data = 32'(data_out);
            OFS_DATA_IN:  rd_data = 32'(filt);
            OFS_DIR:      rd_data = 32'(dir);
            OFS_IRQ_EN:   rd_data = 32'(irq_en);
            OFS_RISE:     rd_data = 32'(rise_mask);
            OFS_FALL:     rd_data = 32'(fall_mask);
            OFS_STATUS:   rd_data = 32'(irq_status);
            OFS_ID:       rd_data = {16'h6710, 8'h00, ID_WIDTH};
            default:      rd_data = 32'd0;
        endcase
    end

    assign HRDATA   = (vld_p1 & ~write_p1) ? rd_data : 32'd0;
    assign gpio_out = data_out;
    assign gpio_oe  = dir;
    assign irq      = |(irq_status & irq_en);

endmodule

// File: tb/tb_ahblite_gpio_irq.sv
// Self-checking bench for ahblite_gpio_irq: register vector table plus interrupt, W1C, pipelining and reset sequences.
module tb_ahblite_gpio_irq;

    localparam int WIDTH = 8;
`ifdef GPIO_DEBOUNCE_EN
    localparam int LAT = 16;
`else
    localparam int LAT = 0;
`endif

    logic             HCLK = 1'b0;
    logic             HRESET;
    logic             HSEL;
    logic [31:0]      HADDR;
    logic [1:0]       HTRANS;
    logic [2:0]       HSIZE;
    logic [3:0]       HPROT;
    logic             HWRITE;
    logic [31:0]      HWDATA;
    logic             HREADY;
    logic             HREADYOUT;
    logic [31:0]      HRDATA;
    logic             HRESP;
    logic [WIDTH-1:0] gpio_in;
    logic [WIDTH-1:0] gpio_out;
    logic [WIDTH-1:0] gpio_oe;
    logic             irq;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 HCLK = ~HCLK;

    ahblite_gpio_irq #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(16)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [7:0]  exp_out;
        logic [7:0]  exp_oe;
    } vec_t;

    vec_t vecs [21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge HCLK);
    endtask

    // Both bus tasks start and end on a falling edge.
    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {24'h0, a};
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
        @(negedge HCLK);
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {24'h0, a};
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00;
        d = HRDATA;
        @(negedge HCLK);
    endtask

    initial begin
        logic [31:0] rd;

        vecs[0]  = '{1'b1, 8'h00, 32'h0000_00A5, 8'hA5, 8'h00};
        vecs[1]  = '{1'b1, 8'h08, 32'h0000_00FF, 8'hA5, 8'hFF};
        vecs[2]  = '{1'b0, 8'h00, 32'h0000_00A5, 8'hA5, 8'hFF};
        vecs[3]  = '{1'b0, 8'h08, 32'h0000_00FF, 8'hA5, 8'hFF};
        vecs[4]  = '{1'b0, 8'h1C, 32'h6710_0008, 8'hA5, 8'hFF};
        vecs[5]  = '{1'b0, 8'h04, 32'h0000_0000, 8'hA5, 8'hFF};
        vecs[6]  = '{1'b1, 8'h04, 32'h0000_00FF, 8'hA5, 8'hFF};
        vecs[7]  = '{1'b0, 8'h04, 32'h0000_0000, 8'hA5, 8'hFF};
        vecs[8]  = '{1'b1, 8'h1C, 32'h0000_0000, 8'hA5, 8'hFF};
        vecs[9]  = '{1'b0, 8'h1C, 32'h6710_0008, 8'hA5, 8'hFF};
        vecs[10] = '{1'b1, 8'h0C, 32'h0000_01FF, 8'hA5, 8'hFF};
        vecs[11] = '{1'b0, 8'h0C, 32'h0000_00FF, 8'hA5, 8'hFF};
        vecs[12] = '{1'b1, 8'h10, 32'hFFFF_FF03, 8'hA5, 8'hFF};
        vecs[13] = '{1'b0, 8'h10, 32'h0000_0003, 8'hA5, 8'hFF};
        vecs[14] = '{1'b1, 8'h0C, 32'h0000_0000, 8'hA5, 8'hFF};
        vecs[15] = '{1'b1, 8'h10, 32'h0000_0000, 8'hA5, 8'hFF};
        vecs[16] = '{1'b1, 8'h00, 32'h0000_003C, 8'h3C, 8'hFF};
        vecs[17] = '{1'b0, 8'h18, 32'h0000_0000, 8'h3C, 8'hFF};
        vecs[18] = '{1'b1, 8'h14, 32'h0000_0012, 8'h3C, 8'hFF};
        vecs[19] = '{1'b0, 8'h14, 32'h0000_0012, 8'h3C, 8'hFF};
        vecs[20] = '{1'b1, 8'h14, 32'h0000_0000, 8'h3C, 8'hFF};

        HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HSIZE = 3'd2; HPROT = 4'd0;
        HWRITE = 1'b0; HWDATA = '0; HREADY = 1'b1; gpio_in = '0;
        wait_cycles(2);
        HRESET = 1'b0;
        wait_cycles(1);

        check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        check("rst_hresp",     32'(HRESP),     32'd0);
        check("rst_hrdata",    HRDATA,         32'd0);
        check("rst_irq",       32'(irq),       32'd0);
        check("rst_gpio_out",  32'(gpio_out),  32'd0);
        check("rst_gpio_oe",   32'(gpio_oe),   32'd0);

        for (int i = 0; i < 21; i++) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].addr, vecs[i].data);
            end else begin
                bus_read(vecs[i].addr, rd);
                check($sformatf("vec%0d_rd_%02h", i, vecs[i].addr), rd, vecs[i].data);
            end
            check($sformatf("vec%0d_gpio_out", i), 32'(gpio_out), 32'(vecs[i].exp_out));
            check($sformatf("vec%0d_gpio_oe", i),  32'(gpio_oe),  32'(vecs[i].exp_oe));
        end

        // Input path reaches DATA_IN; no masks so no status
        gpio_in = 8'h5A;
        wait_cycles(3 + LAT);
        bus_read(8'h04, rd);
        check("data_in_5a", rd, 32'h5A);
        gpio_in = 8'h00;
        wait_cycles(3 + LAT);
        bus_read(8'h04, rd);
        check("data_in_00", rd, 32'h00);
        bus_read(8'h18, rd);
        check("status_unmasked", rd, 32'h00);

        // Rising edge on pin 0 with exact irq latency
        bus_write(8'h10, 32'h01);
        bus_write(8'h0C, 32'h01);
        gpio_in[0] = 1'b1;
        wait_cycles(2 + LAT);
        check("rise_irq_early", 32'(irq), 32'd0);
        wait_cycles(1);
        check("rise_irq", 32'(irq), 32'd1);
        bus_read(8'h18, rd);
        check("rise_status", rd, 32'h01);
        bus_write(8'h18, 32'h01);
        check("rise_clr_irq", 32'(irq), 32'd0);
        bus_read(8'h18, rd);
        check("rise_clr_status", rd, 32'h00);

        // Falling edge on pin 7 captured while masked off from irq
        gpio_in[7] = 1'b1;
        wait_cycles(4 + LAT);
        bus_write(8'h14, 32'h80);
        bus_write(8'h0C, 32'h00);
        gpio_in[7] = 1'b0;
        wait_cycles(4 + LAT);
        bus_read(8'h18, rd);
        check("fall_status", rd, 32'h80);
        check("fall_irq_masked", 32'(irq), 32'd0);
        bus_write(8'h0C, 32'h80);
        check("fall_irq_enabled", 32'(irq), 32'd1);
        bus_write(8'h18, 32'h80);
        check("fall_clr_irq", 32'(irq), 32'd0);

`ifdef GPIO_DEBOUNCE_EN
        bus_write(8'h10, 32'h05);
        gpio_in[2] = 1'b1;
        wait_cycles(4);
        bus_read(8'h04, rd);
        check("deb_data_in_glitch", rd, 32'h01);
        wait_cycles(4);
        gpio_in[2] = 1'b0;
        wait_cycles(30);
        bus_read(8'h18, rd);
        check("deb_short_status", rd, 32'h00);
        gpio_in[2] = 1'b1;
        wait_cycles(20);
        gpio_in[2] = 1'b0;
        wait_cycles(30);
        bus_read(8'h18, rd);
        check("deb_long_status", rd, 32'h04);
        bus_write(8'h18, 32'h04);
        bus_write(8'h10, 32'h01);
`endif

        // W1C lands on the same edge as a new rising-edge set on pin 0
        bus_write(8'h0C, 32'h01);
        gpio_in[0] = 1'b0;
        wait_cycles(4 + LAT);
        bus_read(8'h18, rd);
        check("coll_pre_status", rd, 32'h00);
        gpio_in[0] = 1'b1;
        wait_cycles(1 + LAT);
        bus_write(8'h18, 32'h01);
        bus_read(8'h18, rd);
        check("coll_status", rd, 32'h01);
        check("coll_irq", 32'(irq), 32'd1);
        bus_write(8'h18, 32'h00);
        bus_read(8'h18, rd);
        check("w1c_zero_noop", rd, 32'h01);

        // Pipelined write then read of the same register
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h00;
        @(negedge HCLK);
        HWDATA = 32'h5C; HWRITE = 1'b0; HADDR = 32'h00;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00;
        check("b2b_read", HRDATA, 32'h5C);
        @(negedge HCLK);
        check("b2b_gpio_out", 32'(gpio_out), 32'h5C);

        // Reset during a write data phase discards the write
        gpio_in = '0;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h00;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h77;
        #2 HRESET = 1'b1;
        #1 check("rstmid_irq_async", 32'(irq), 32'd0);
        @(negedge HCLK);
        HRESET = 1'b0;
        @(negedge HCLK);
        check("rstmid_gpio_out", 32'(gpio_out), 32'd0);
        check("rstmid_gpio_oe",  32'(gpio_oe),  32'd0);
        for (int a = 0; a < 7; a++) begin
            bus_read(8'(a * 4), rd);
            check($sformatf("rstmid_rd_%02h", a * 4), rd, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
